// File: rtl/riscv_load_wb_queue_if.sv
// Load write-back queue bus bundle.
//   issue_*  : LSU side, one entry per load sent to data memory
//   resp_*   : data-memory read return, in order, one per issue
//   *_b_o    : register-file write port W2
//   pending_o/err_o/spurious_o/empty_o : status toward decode / debug
// slave modport is the queue itself; master modport is whoever drives it.
interface riscv_load_wb_queue_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    localparam int NUM_WORDS = 2 ** ADDR_WIDTH;

    logic                  issue_valid_i;
    logic                  issue_ready_o;
    logic [ADDR_WIDTH-1:0] issue_rd_i;
    logic [1:0]            issue_size_i;
    logic                  issue_sign_i;
    logic [1:0]            issue_offset_i;
    logic                  resp_valid_i;
    logic [DATA_WIDTH-1:0] resp_rdata_i;
    logic                  resp_err_i;
    logic                  we_b_o;
    logic [ADDR_WIDTH-1:0] waddr_b_o;
    logic [DATA_WIDTH-1:0] wdata_b_o;
    logic [NUM_WORDS-1:0]  pending_o;
    logic                  err_o;
    logic                  spurious_o;
    logic                  empty_o;

    modport slave (
        input  issue_valid_i, issue_rd_i, issue_size_i, issue_sign_i, issue_offset_i,
        input  resp_valid_i, resp_rdata_i, resp_err_i,
        output issue_ready_o, we_b_o, waddr_b_o, wdata_b_o,
        output pending_o, err_o, spurious_o, empty_o
    );

    modport master (
        output issue_valid_i, issue_rd_i, issue_size_i, issue_sign_i, issue_offset_i,
        output resp_valid_i, resp_rdata_i, resp_err_i,
        input  issue_ready_o, we_b_o, waddr_b_o, wdata_b_o,
        input  pending_o, err_o, spurious_o, empty_o
    );
endinterface

// File: rtl/riscv_load_wb_queue.sv
// Outstanding-load tracker between LSU issue and data return.
// Each issued load stores {rd, size, sign, offset}; the in-order response pops
// the head, aligns/extends the word and writes it through port W2 one cycle
// later. pending_o flags every register targeted by a queued load so decode
// can stall on load-use hazards.
// Ports: clk, rst_n (sync, active low), bus (riscv_load_wb_queue_if.slave).
module riscv_load_wb_queue #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic clk,
    input  logic rst_n,
    riscv_load_wb_queue_if.slave bus
);
    localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [1:0]            size;
        logic                  sign;
        logic [1:0]            offset;
    } entry_t;

    entry_t                q [DEPTH];
    logic [DEPTH-1:0]      vld;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  ready, push, pop;
    entry_t                head, new_entry;
    logic [DATA_WIDTH-1:0] sh, ext;
    logic [15:0]           half;
    logic [NUM_WORDS-1:0]  pend;

    logic                  we_q, err_q, spur_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    assign ready     = (count < CNT_W'(DEPTH));
    assign push      = bus.issue_valid_i && ready;
    assign pop       = bus.resp_valid_i && (count != '0);
    assign head      = q[rd_ptr];
    assign new_entry = '{rd: bus.issue_rd_i, size: bus.issue_size_i,
                         sign: bus.issue_sign_i, offset: bus.issue_offset_i};

    // Byte lane select by shifting the word down by 8*offset.
    always_comb begin
        sh   = bus.resp_rdata_i >> {head.offset, 3'b000};
        half = head.offset[1] ? bus.resp_rdata_i[31:16] : bus.resp_rdata_i[15:0];
        case (head.size)
            2'b00:   ext = {{24{head.sign & sh[7]}}, sh[7:0]};
            2'b01:   ext = {{16{head.sign & half[15]}}, half};
            default: ext = bus.resp_rdata_i;
        endcase
    end

    // Pending mask from live entries; x0 never needs a stall.
    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++)
            if (vld[i]) pend[q[i].rd] = 1'b1;
        pend[0] = 1'b0;
    end

    // Entry payload needs no reset: vld gates every use.
    always_ff @(posedge clk) begin
        if (push) q[wr_ptr] <= new_entry;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            vld     <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            spur_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q   <= 1'b0;
            err_q  <= 1'b0;
            spur_q <= bus.resp_valid_i && (count == '0);
            // wr_ptr == rd_ptr only when empty (no pop) or full (no push),
            // so the two vld updates never hit the same slot.
            if (push) begin
                wr_ptr      <= wr_ptr + 1'b1;
                vld[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                vld[rd_ptr] <= 1'b0;
                if (bus.resp_err_i) begin
                    err_q   <= 1'b1;
                    waddr_q <= head.rd;
                end else if (head.rd != '0) begin
                    we_q    <= 1'b1;
                    waddr_q <= head.rd;
                    wdata_q <= ext;
                end
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.issue_ready_o = ready;
    assign bus.empty_o       = (count == '0);
    assign bus.pending_o     = pend;
    assign bus.we_b_o        = we_q;
    assign bus.waddr_b_o     = waddr_q;
    assign bus.wdata_b_o     = wdata_q;
    assign bus.err_o         = err_q;
    assign bus.spurious_o    = spur_q;
endmodule
